fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer.sv | 134 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Packs PACK first-word-fall-through FIFO entries little-endian into one word; final pop -> out_valid next cycle.
// A presented word is held until out_ready; no pops happen while a word is presented, so the FIFO absorbs stalls.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4,
    parameter int CNTW  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK*DSIZE-1:0] out_data,
    output logic [PACK-1:0]       out_keep,
    output logic [CNTW-1:0]       word_cnt,
    output logic                  busy
);

    localparam int IDXW = $clog2(PACK);
    localparam int WW   = PACK * DSIZE;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PACK - 1);

    if (PACK < 2 || PACK > 8) begin : g_bad_pack
        $error("fifo_rd_packer: PACK must be in 2..8");
    end

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_e;

    state_e          state_q,    state_d;
    logic [IDXW-1:0] fill_idx_q, fill_idx_d;
    logic [WW-1:0]   lane_q,     lane_d;
    logic [WW-1:0]   out_data_q, out_data_d;
    logic [PACK-1:0] out_keep_q, out_keep_d;
    logic [CNTW-1:0] word_cnt_q, word_cnt_d;

    logic            pop;
    logic            flush_go;
    logic            accept;
    logic [WW-1:0]   lane_wr;
    logic [PACK-1:0] part_keep;

    assign rinc     = (state_q == S_FILL) & ~rempty & ~flush & ~rrst;
    assign pop      = rinc;
    assign flush_go = (state_q == S_FILL) & flush & (fill_idx_q != '0);
    assign accept   = (state_q == S_OUT) & out_ready;

    // Held lanes with the current head entry merged into lane fill_idx,
    // plus the keep mask covering lanes already filled.
    always_comb begin
        lane_wr   = lane_q;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (fill_idx_q == IDXW'(i)) begin
                lane_wr[i*DSIZE +: DSIZE] = rdata;
            end
            if (IDXW'(i) < fill_idx_q) begin
                part_keep[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        lane_d     = lane_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            S_FILL: begin
                if (flush_go) begin
                    state_d    = S_OUT;
                    out_data_d = lane_q;
                    out_keep_d = part_keep;
                    lane_d     = '0;
                    fill_idx_d = '0;
                end else if (pop) begin
                    if (fill_idx_q == LAST_IDX) begin
                        state_d    = S_OUT;
                        out_data_d = lane_wr;
                        out_keep_d = '1;
                        lane_d     = '0;
                        fill_idx_d = '0;
                    end else begin
                        lane_d     = lane_wr;
                        fill_idx_d = fill_idx_q + IDXW'(1);
                    end
                end
            end
            S_OUT: begin
                if (accept) begin
                    state_d    = S_FILL;
                    out_data_d = '0;
                    out_keep_d = '0;
                    word_cnt_d = word_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q    <= S_FILL;
            fill_idx_q <= '0;
            lane_q     <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            lane_q     <= lane_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign word_cnt  = word_cnt_q;
    assign busy      = out_valid | (fill_idx_q != '0);

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed vector table, hand-written corner sequences and a randomized scoreboard run for fifo_rd_packer.
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        flush;
    logic        out_ready;

    logic        rinc,  rinc2;
    logic        out_valid, out_valid2;
    logic [31:0] out_data,  out_data2;
    logic [3:0]  out_keep,  out_keep2;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt2;
    logic        busy, busy2;

    int tests = 0;
    int fails = 0;

    fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(16)) u_dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .word_cnt(word_cnt), .busy(busy)
    );

    fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(4)) u_dut_w4 (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc2),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_keep(out_keep2), .word_cnt(word_cnt2), .busy(busy2)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // ctl = {rrst, rempty, flush, out_ready}; flg = {rinc, out_valid, busy}
    typedef struct {
        logic [3:0]  ctl;
        logic [7:0]  d;
        logic [2:0]  flg;
        logic [31:0] xd;
        logic [3:0]  xk;
        logic [15:0] xc;
    } vec_t;

    vec_t vecs[19];

    logic [7:0] expq[$];
    int         words_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic rdy, input logic [7:0] d);
        rrst      = r;
        rempty    = e;
        flush     = f;
        out_ready = rdy;
        rdata     = d;
    endtask

    task automatic nxt();
        @(posedge rclk);
        #1;
    endtask

    task automatic check_word();
        logic [3:0] k;
        k = out_keep;
        words_seen++;
        chk("rand.keep_contig", ((k & (k + 4'd1)) == 4'd0) && (k != 4'd0), 1);
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                if (expq.size() == 0) begin
                    chk($sformatf("rand.extra_lane%0d", i), 1, 0);
                end else begin
                    chk($sformatf("rand.lane%0d", i), out_data[i*8 +: 8], expq.pop_front());
                end
            end else begin
                chk($sformatf("rand.unused_lane%0d", i), out_data[i*8 +: 8], 0);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1001, 8'h11, 3'b000, 32'h0,        4'h0, 16'd0};
        vecs[1]  = '{4'b0001, 8'h11, 3'b100, 32'h0,        4'h0, 16'd0};
        vecs[2]  = '{4'b0001, 8'h22, 3'b101, 32'h0,        4'h0, 16'd0};
        vecs[3]  = '{4'b0001, 8'h33, 3'b101, 32'h0,        4'h0, 16'd0};
        vecs[4]  = '{4'b0001, 8'h44, 3'b101, 32'h0,        4'h0, 16'd0};
        vecs[5]  = '{4'b0001, 8'h55, 3'b011, 32'h44332211, 4'hF, 16'd0};
        vecs[6]  = '{4'b0101, 8'h00, 3'b000, 32'h0,        4'h0, 16'd1};
        vecs[7]  = '{4'b0001, 8'h0A, 3'b100, 32'h0,        4'h0, 16'd1};
        vecs[8]  = '{4'b0001, 8'h0B, 3'b101, 32'h0,        4'h0, 16'd1};
        vecs[9]  = '{4'b0001, 8'h0C, 3'b101, 32'h0,        4'h0, 16'd1};
        vecs[10] = '{4'b0101, 8'hEE, 3'b001, 32'h0,        4'h0, 16'd1};
        vecs[11] = '{4'b0101, 8'hEE, 3'b001, 32'h0,        4'h0, 16'd1};
        vecs[12] = '{4'b0011, 8'h0D, 3'b001, 32'h0,        4'h0, 16'd1};
        vecs[13] = '{4'b0000, 8'h0D, 3'b011, 32'h000C0B0A, 4'h7, 16'd1};
        vecs[14] = '{4'b0011, 8'h0D, 3'b011, 32'h000C0B0A, 4'h7, 16'd1};
        vecs[15] = '{4'b0011, 8'h0D, 3'b000, 32'h0,        4'h0, 16'd2};
        vecs[16] = '{4'b0001, 8'h0D, 3'b100, 32'h0,        4'h0, 16'd2};
        vecs[17] = '{4'b1001, 8'h0E, 3'b001, 32'h0,        4'h0, 16'd2};
        vecs[18] = '{4'b0101, 8'h00, 3'b000, 32'h0,        4'h0, 16'd0};

        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) nxt();

        // Each row: inputs applied after an edge, outputs sampled mid-cycle before the next edge.
        for (int i = 0; i < 19; i++) begin
            {rrst, rempty, flush, out_ready} = vecs[i].ctl;
            rdata = vecs[i].d;
            @(negedge rclk);
            chk($sformatf("v%0d.rinc", i),      rinc,      vecs[i].flg[2]);
            chk($sformatf("v%0d.valid", i),     out_valid, vecs[i].flg[1]);
            chk($sformatf("v%0d.busy", i),      busy,      vecs[i].flg[0]);
            chk($sformatf("v%0d.data", i),      out_data,  vecs[i].xd);
            chk($sformatf("v%0d.keep", i),      out_keep,  vecs[i].xk);
            chk($sformatf("v%0d.cnt", i),       word_cnt,  vecs[i].xc);
            chk($sformatf("v%0d.w4_rinc", i),   rinc2,     vecs[i].flg[2]);
            chk($sformatf("v%0d.w4_valid", i),  out_valid2, vecs[i].flg[1]);
            chk($sformatf("v%0d.w4_busy", i),   busy2,     vecs[i].flg[0]);
            chk($sformatf("v%0d.w4_data", i),   out_data2, vecs[i].xd);
            chk($sformatf("v%0d.w4_keep", i),   out_keep2, vecs[i].xk);
            chk($sformatf("v%0d.w4_cnt", i),    word_cnt2, vecs[i].xc[3:0]);
            nxt();
        end

        // Backpressure: full word held for 5 cycles with data available upstream.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i));
            @(negedge rclk);
            chk($sformatf("bp.fill_rinc%0d", i), rinc, 1);
            nxt();
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
            @(negedge rclk);
            chk($sformatf("bp.hold_rinc%0d", k),  rinc,      0);
            chk($sformatf("bp.hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp.hold_data%0d", k),  out_data,  32'hA3A2A1A0);
            chk($sformatf("bp.hold_keep%0d", k),  out_keep,  4'hF);
            nxt();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        @(negedge rclk);
        chk("bp.accept_valid", out_valid, 1);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hB0);
        @(negedge rclk);
        chk("bp.after_valid", out_valid, 0);
        chk("bp.after_cnt",   word_cnt,  16'd1);
        chk("bp.resume_rinc", rinc,      1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
        nxt();

        // Reset mid-word discards partial lanes.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC1);
        nxt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC2);
        nxt();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hC3);
        @(negedge rclk);
        chk("rst.rinc_during", rinc, 0);
        chk("rst.busy_before", busy, 1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hD1 + 8'(i));
            @(negedge rclk);
            if (i == 0) begin
                chk("rst.valid", out_valid, 0);
                chk("rst.data",  out_data,  0);
                chk("rst.keep",  out_keep,  0);
                chk("rst.cnt",   word_cnt,  0);
                chk("rst.busy",  busy,      0);
            end
            chk($sformatf("rst.pop_rinc%0d", i), rinc, 1);
            nxt();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
        @(negedge rclk);
        chk("rst.fresh_valid", out_valid, 1);
        chk("rst.fresh_data",  out_data,  32'hD4D3D2D1);
        chk("rst.fresh_keep",  out_keep,  4'hF);
        nxt();

        // 17 back-to-back words: throughput PACK+1 and 4-bit counter wrap.
        begin
            int vld_cnt;
            int pop_cnt;
            vld_cnt = 0;
            pop_cnt = 0;
            drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
            nxt();
            for (int c = 0; c < 85; c++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(c));
                @(negedge rclk);
                if (out_valid) vld_cnt++;
                if (rinc) pop_cnt++;
                nxt();
            end
            drive(1'b0, 1'b1, 1'b0, 1'b1, 8'hEE);
            @(negedge rclk);
            chk("wrap.cnt16",    word_cnt,  16'd17);
            chk("wrap.cnt4",     word_cnt2, 4'd1);
            chk("wrap.words",    vld_cnt,   17);
            chk("wrap.pops",     pop_cnt,   68);
            chk("wrap.idle",     busy,      0);
            nxt();
        end

        // Randomized traffic against a popped-entry scoreboard.
        begin
            logic [7:0] nv;
            logic       e, f, rdy;
            nv = 8'h01;
            words_seen = 0;
            drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
            nxt();
            for (int c = 0; c < 500; c++) begin
                e   = ($urandom_range(3) == 0);
                f   = ($urandom_range(7) == 0);
                rdy = ($urandom_range(2) != 0);
                drive(1'b0, e, f, rdy, e ? 8'hEE : nv);
                @(negedge rclk);
                if (out_valid && out_ready) check_word();
                if (rinc && !rempty) begin
                    expq.push_back(nv);
                    nv++;
                end
                nxt();
            end
            for (int c = 0; c < 12; c++) begin
                drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE);
                @(negedge rclk);
                if (out_valid && out_ready) check_word();
                chk($sformatf("drain.rinc%0d", c), rinc, 0);
                nxt();
            end
            @(negedge rclk);
            chk("rand.leftover",   expq.size(), 0);
            chk("rand.idle_busy",  busy,        0);
            chk("rand.some_words", words_seen > 20, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
